rf_writeback_unit: RTL
======================

# rf_writeback_unit

Parametrised register-file writeback stage for the RV32I/RV64I core. It replaces the purely combinational writeback select with a registered unit that:
- accepts one writeback request per cycle from execute;
- waits for load data via a response handshake with a timeout;
- aligns and sign/zero-extends sub-word loads using the byte offset;
- drives the register-file write port one cycle after the result is known.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- LOAD_TIMEOUT, 255, maximum cycles spent in WAIT_LOAD before a fault is raised; legal range 1..65535.

Ports:
- clk  in  1  core clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_valid  in  1  writeback request from execute.
- wb_ready  out  1  the unit accepts a request this cycle.
- opcode  in  7  RV32I_OPCODE_t of the instruction.
- funct3  in  3  load size/sign encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD (XLEN=64 only), 110 LWU (XLEN=64 only).
- rd_addr  in  5  destination register.
- alu_out  in  XLEN  execute result.
- pc_plus_4  in  XLEN  link value.
- load_offset  in  log2(XLEN/8)  byte offset of the load address within the bus word.
- bus_rvalid  in  1  load data valid.
- bus_rddata  in  XLEN  load data word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- stall  out  1  high while a load response is pending.
- load_fault  out  1  one-cycle pulse on load timeout or misalignment.

## Operation
- FSM has two states: IDLE and WAIT_LOAD.
- In IDLE, wb_ready=1. A handshake occurs when wb_valid=1 in IDLE.
- Accepted R_TYPE, I_TYPE, U_LUI_TYPE or U_AUI_TYPE: next cycle rf_we=1 and rf_wdata=alu_out.
- Accepted I_JALR_TYPE or J_TYPE: next cycle rf_we=1 and rf_wdata=pc_plus_4.
- Accepted I_LOAD_TYPE with legal funct3: go to WAIT_LOAD and clear the timeout counter.
- Accepted I_LOAD_TYPE with illegal funct3 (011 or 110 when XLEN=32; 111 always): no bus wait; next cycle rf_we=1 and rf_wdata=0.
- Any other accepted opcode: consumed, no write.
- rd_addr=0: rf_we is never asserted, but the handshake and FSM behaviour are unchanged.
- In WAIT_LOAD: wb_ready=0 and stall=1.
  - On bus_rvalid: select the byte lane starting at load_offset×8, extend to XLEN (sign extension for LB/LH/LW; zero extension for LBU/LHU/LWU; LD passes through), write next cycle, and return to IDLE.
  - The counter increments each cycle without bus_rvalid. At count == LOAD_TIMEOUT-1 with no bus_rvalid: load_fault pulses next cycle, no write, and the FSM returns to IDLE.
  - bus_rvalid and timeout in the same cycle: data wins, no fault.
- bus_rvalid while in IDLE is ignored.
- Without WB_MISALIGN_TRAP_EN, load_offset is aligned down to the access size: halfword uses offset & ~1, word uses offset & ~3, doubleword uses 0.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, load_fault=0, stall=0, FSM=IDLE, counter=0. wb_ready=1 in the cycle after rst deasserts.
- Non-load latency: exactly 1 cycle from acceptance to rf_we. Back-to-back acceptance is allowed every cycle.
- Load latency: earliest bus_rvalid is the cycle after acceptance; rf_we follows 1 cycle after bus_rvalid, giving a minimum of 2 cycles.
- rf_we, rf_waddr, rf_wdata and load_fault are registered. stall and wb_ready are combinational from the FSM state.
- rst asserted mid-load: the pending load is dropped with no write and no fault. A late bus_rvalid after reset is ignored.

## Configuration
- WB_MISALIGN_TRAP_EN defined: misaligned loads are trapped.
  - Misaligned means LH/LHU with odd offset, LW/LWU with offset%4≠0, or LD with offset≠0.
  - Such a load skips WAIT_LOAD, pulses load_fault 1 cycle after acceptance, performs no write, and leaves wb_ready at 1.
- Undefined: no misalignment check; offsets are aligned down as described in Operation.

## Test plan
- Reset: hold rst 3 cycles with wb_valid=1 -> all outputs 0 during reset; first acceptance occurs only after release.
- R_TYPE followed immediately by J_TYPE, rd=5 then rd=1, alu_out=0x1234, pc_plus_4=0x104 -> rf_we on 2 consecutive cycles with 0x1234@x5, then 0x104@x1.
- LB with offset=2, bus_rddata=0x00800000, bus_rvalid 3 cycles after acceptance -> stall high 3 cycles; rf_wdata=0xFFFFFF80.
- LHU with offset=2, bus_rddata=0xBEEF0000, XLEN=32 -> rf_wdata=0x0000BEEF; LH on the same data -> 0xFFFFBEEF.
- Load with LOAD_TIMEOUT=4 and no bus_rvalid -> load_fault pulse 4 cycles after entering WAIT_LOAD, no rf_we, FSM back to IDLE; bus_rvalid 2 cycles later is ignored.
- LW with offset=1 -> with WB_MISALIGN_TRAP_EN: load_fault 1 cycle after acceptance, no stall. Without the macro: word read from offset 0 after bus_rvalid.

Source files
------------

// File: rtl/rf_writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_unit_if
//  Description : Bundle of the execute request, load-response bus and
//                register-file write port seen by the writeback stage.
//                master : execute / memory side (drives requests and
//                         load responses, observes the results)
//                slave  : rf_writeback_unit
//  Signals     : wb_valid/wb_ready   request handshake
//                opcode, funct3, rd_addr, alu_out, pc_plus_4, load_offset
//                bus_rvalid, bus_rddata   load response
//                rf_we, rf_waddr, rf_wdata   register-file write port
//                stall, load_fault   status
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_writeback_unit_if #(
    parameter int XLEN = 32
);
    localparam int OFFW = $clog2(XLEN / 8);

    logic              wb_valid;
    logic              wb_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   pc_plus_4;
    logic [OFFW-1:0]   load_offset;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rddata;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              stall;
    logic              load_fault;

    modport master (
        output wb_valid, opcode, funct3, rd_addr, alu_out, pc_plus_4,
               load_offset, bus_rvalid, bus_rddata,
        input  wb_ready, rf_we, rf_waddr, rf_wdata, stall, load_fault
    );

    modport slave (
        input  wb_valid, opcode, funct3, rd_addr, alu_out, pc_plus_4,
               load_offset, bus_rvalid, bus_rddata,
        output wb_ready, rf_we, rf_waddr, rf_wdata, stall, load_fault
    );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_unit
//  Description : Registered writeback stage. Accepts one request per cycle,
//                waits (with timeout) for load data, aligns and extends
//                sub-word loads and drives the register-file write port one
//                cycle after the result is known.
//  Ports       : clk   core clock (rising edge)
//                rst   synchronous active-high reset
//                wb    rf_writeback_unit_if.slave (request, load bus,
//                      register-file write port, stall, load_fault)
//  Parameters  : XLEN          32 or 64
//                LOAD_TIMEOUT  1..65535 cycles waiting for load data
//  Macro       : WB_MISALIGN_TRAP_EN - trap misaligned loads with a
//                load_fault pulse instead of aligning the offset down
//  Revision    : 1.0  initial release
// ============================================================================
module rf_writeback_unit #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 255
) (
    input  wire logic            clk,
    input  wire logic            rst,
    rf_writeback_unit_if.slave   wb
);
    localparam int OFFW = $clog2(XLEN / 8);

    localparam logic [6:0] c_op_r_type  = 7'b0110011;
    localparam logic [6:0] c_op_i_type  = 7'b0010011;
    localparam logic [6:0] c_op_lui     = 7'b0110111;
    localparam logic [6:0] c_op_auipc   = 7'b0010111;
    localparam logic [6:0] c_op_jalr    = 7'b1100111;
    localparam logic [6:0] c_op_jal     = 7'b1101111;
    localparam logic [6:0] c_op_load    = 7'b0000011;
    localparam logic [15:0] c_timeout_last = 16'(LOAD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [2:0]        ld_funct3_q, ld_funct3_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic [OFFW-1:0]   ld_off_q, ld_off_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              load_fault_q, load_fault_d;

    logic              w_f3_legal;
    logic [OFFW-1:0]   w_align_mask;
    logic [OFFW-1:0]   w_eff_off;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_do_write;
    logic [4:0]        w_write_rd;
    logic [XLEN-1:0]   w_write_data;

    // LD and LWU only exist on RV64.
    always_comb begin
        w_f3_legal = 1'b0;
        case (wb.funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_legal = 1'b1;
            3'b011, 3'b110:                         w_f3_legal = (XLEN == 64);
            default:                                w_f3_legal = 1'b0;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        case (wb.funct3[1:0])
            2'b01:   w_misaligned = wb.load_offset[0];
            2'b10:   w_misaligned = (wb.load_offset[1:0] != 2'b00);
            2'b11:   w_misaligned = (wb.load_offset != '0);
            default: w_misaligned = 1'b0;
        endcase
    end
`endif

    // Offset is forced down to the access size. In trap mode only aligned
    // offsets reach WAIT_LOAD, so the mask is then a no-op.
    always_comb begin
        w_align_mask = '1;
        case (ld_funct3_q[1:0])
            2'b01:   w_align_mask = ~(OFFW'(1));
            2'b10:   w_align_mask = ~(OFFW'(3));
            2'b11:   w_align_mask = '0;
            default: w_align_mask = '1;
        endcase
    end

    assign w_eff_off = ld_off_q & w_align_mask;
    assign w_shifted = wb.bus_rddata >> {w_eff_off, 3'b000};

    always_comb begin
        w_ld_data = w_shifted;
        case (ld_funct3_q)
            3'b000:  w_ld_data = XLEN'($signed(w_shifted[7:0]));
            3'b100:  w_ld_data = XLEN'(w_shifted[7:0]);
            3'b001:  w_ld_data = XLEN'($signed(w_shifted[15:0]));
            3'b101:  w_ld_data = XLEN'(w_shifted[15:0]);
            3'b010:  w_ld_data = XLEN'($signed(w_shifted[31:0]));
            3'b110:  w_ld_data = XLEN'(w_shifted[31:0]);
            default: w_ld_data = w_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        ld_funct3_d  = ld_funct3_q;
        ld_rd_d      = ld_rd_q;
        ld_off_d     = ld_off_q;
        load_fault_d = 1'b0;
        w_do_write   = 1'b0;
        w_write_rd   = wb.rd_addr;
        w_write_data = '0;

        case (state_q)
            IDLE: begin
                if (wb.wb_valid) begin
                    case (wb.opcode)
                        c_op_r_type, c_op_i_type, c_op_lui, c_op_auipc: begin
                            w_do_write   = 1'b1;
                            w_write_data = wb.alu_out;
                        end
                        c_op_jalr, c_op_jal: begin
                            w_do_write   = 1'b1;
                            w_write_data = wb.pc_plus_4;
                        end
                        c_op_load: begin
                            if (!w_f3_legal) begin
                                // Illegal size: retire a zero without a bus wait.
                                w_do_write   = 1'b1;
                                w_write_data = '0;
                            end else
`ifdef WB_MISALIGN_TRAP_EN
                            if (w_misaligned) begin
                                load_fault_d = 1'b1;
                            end else
`endif
                            begin
                                state_d     = WAIT_LOAD;
                                count_d     = '0;
                                ld_funct3_d = wb.funct3;
                                ld_rd_d     = wb.rd_addr;
                                ld_off_d    = wb.load_offset;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_LOAD: begin
                // Data in the timeout cycle takes priority over the fault.
                if (wb.bus_rvalid) begin
                    w_do_write   = 1'b1;
                    w_write_rd   = ld_rd_q;
                    w_write_data = w_ld_data;
                    state_d      = IDLE;
                end else if (count_q == c_timeout_last) begin
                    load_fault_d = 1'b1;
                    count_d      = '0;
                    state_d      = IDLE;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // x0 is never written; waddr/wdata hold their last written value.
        rf_we_d    = w_do_write && (w_write_rd != 5'd0);
        rf_waddr_d = rf_we_d ? w_write_rd   : rf_waddr_q;
        rf_wdata_d = rf_we_d ? w_write_data : rf_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            ld_funct3_q  <= '0;
            ld_rd_q      <= '0;
            ld_off_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            load_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_rd_q      <= ld_rd_d;
            ld_off_q     <= ld_off_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            load_fault_q <= load_fault_d;
        end
    end

    // Status is combinational from the state; both read low while in reset.
    assign wb.wb_ready   = (state_q == IDLE) && !rst;
    assign wb.stall      = (state_q == WAIT_LOAD) && !rst;
    assign wb.rf_we      = rf_we_q;
    assign wb.rf_waddr   = rf_waddr_q;
    assign wb.rf_wdata   = rf_wdata_q;
    assign wb.load_fault = load_fault_q;

endmodule
`default_nettype wire
